// File: rtl/dcmi_sensor_gen_if.sv
// dcmi_sensor_gen_if: DCMI pin bundle between a sensor model and a capture block.
// Signals: pclk, vsync, hsync, data[DW-1:0]; master drives, slave samples.
interface dcmi_sensor_gen_if #(
  parameter int DW = 8
);
  logic          pclk;
  logic          vsync;
  logic          hsync;
  logic [DW-1:0] data;

  modport master (output pclk, vsync, hsync, data);
  modport slave  (input  pclk, vsync, hsync, data);
endinterface

// File: rtl/dcmi_sensor_gen.sv
// dcmi_sensor_gen: DCMI camera sensor model, external or embedded sync, ramp/LFSR frames.
// Ports: pclk_raw, rstn (async low), start/stop/snapshot, embd_en, pclk/vsync/hsync pol,
//   fsc/fec/lsc/lec codes, line_size/pixel_size; dcmi (master) pins; busy, frame_done, cfg_err.
// Optional: DCMI_GEN_LFSR_EN selects a 16-bit LFSR pixel source instead of the ramp.
module dcmi_sensor_gen #(
  parameter int DW     = 8,
  parameter int LW     = 14,
  parameter int VBLANK = 20,
  parameter int HBLANK = 20
) (
  input  logic          pclk_raw,
  input  logic          rstn,
  input  logic          start,
  input  logic          stop,
  input  logic          snapshot,
  input  logic          embd_en,
  input  logic          pclk_pol,
  input  logic          vsync_pol,
  input  logic          hsync_pol,
  input  logic [7:0]    fsc,
  input  logic [7:0]    fec,
  input  logic [7:0]    lsc,
  input  logic [7:0]    lec,
  input  logic [LW-1:0] line_size,
  input  logic [LW-1:0] pixel_size,
  dcmi_sensor_gen_if.master dcmi,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  localparam int CW = 16;
  localparam logic [CW-1:0] VB_LAST = CW'(VBLANK - 1);
  localparam logic [CW-1:0] HB_LAST = CW'(HBLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FS, S_LS, S_SAV, S_LINE, S_EAV, S_LE, S_FE
  } state_e;

  typedef struct packed {
    logic          snap;
    logic          embd;
    logic          ppol;
    logic          vpol;
    logic          hpol;
    logic [7:0]    fsc;
    logic [7:0]    fec;
    logic [7:0]    lsc;
    logic [7:0]    lec;
    logic [LW-1:0] lines;
    logic [LW-1:0] pix;
  } cfg_t;

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d, cfg_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] line_q, line_d;
  logic [15:0]   frame_q, frame_d;
  logic          go_q, go_d;
  logic          stop_q, stop_d;
  logic          vs_q, vs_d;
  logic          hs_q, hs_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, done_q, done_d;
  logic          err_q, err_d;
  logic          sizes_ok, last_line;

`ifdef DCMI_GEN_LFSR_EN
  localparam logic [15:0] SEED = 16'hACE1;
  logic [15:0] lfsr_q, lfsr_d;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction
`else
  logic [15:0] ramp;
`endif

  // SAV/EAV word sequence: all-ones, 0, 0, code
  function automatic logic [DW-1:0] sync_word(
    input logic [1:0] idx,
    input logic [7:0] code
  );
    logic [DW-1:0] w;
    w = '0;
    if (idx == 2'd0) w = '1;
    if (idx == 2'd3) w = DW'(code);
    return w;
  endfunction

  assign cfg_in = '{snapshot, embd_en, pclk_pol, vsync_pol,
                    hsync_pol, fsc, fec, lsc, lec,
                    line_size, pixel_size};

  assign sizes_ok  = (line_size != '0) && (pixel_size != '0);
  assign last_line = (line_q == cfg_q.lines - LW'(1));

  always_comb begin
    state_d = state_q;
    cfg_d   = cfg_q;
    cnt_d   = cnt_q + CW'(1);
    line_d  = line_q;
    frame_d = frame_q;
    go_d    = go_q;
    vs_d    = vs_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    hs_d    = 1'b0;
    data_d  = '0;
    stop_d  = (state_q == S_IDLE) ? 1'b0 : (stop_q | stop);
`ifdef DCMI_GEN_LFSR_EN
    lfsr_d  = lfsr_q;
`else
    ramp    = '0;
`endif

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        vs_d  = 1'b0;
        // one cycle between acceptance and FS entry
        if (go_q) begin
          go_d    = 1'b0;
          state_d = S_FS;
          line_d  = '0;
`ifdef DCMI_GEN_LFSR_EN
          lfsr_d  = SEED;
`endif
        end else if (start) begin
          if (sizes_ok) begin
            go_d  = 1'b1;
            cfg_d = cfg_in;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_FS: begin
        if (cnt_q == VB_LAST) begin
          state_d = S_LS;
          cnt_d   = '0;
          vs_d    = ~cfg_q.embd;
        end
      end
      S_LS: begin
        if (cnt_q == HB_LAST) begin
          state_d = cfg_q.embd ? S_SAV : S_LINE;
          cnt_d   = '0;
        end
      end
      S_SAV: begin
        if (cnt_q == CW'(3)) begin
          state_d = S_LINE;
          cnt_d   = '0;
        end
      end
      S_LINE: begin
        if (cnt_q == CW'(cfg_q.pix) - CW'(1)) begin
          state_d = cfg_q.embd ? S_EAV : S_LE;
          cnt_d   = '0;
        end
      end
      S_EAV: begin
        if (cnt_q == CW'(3)) begin
          state_d = S_LE;
          cnt_d   = '0;
        end
      end
      S_LE: begin
        cnt_d = '0;
        if (last_line) begin
          state_d = S_FE;
        end else begin
          state_d = S_LS;
          line_d  = line_q + LW'(1);
        end
      end
      S_FE: begin
        if (cnt_q == VB_LAST) begin
          done_d  = 1'b1;
          frame_d = frame_q + 16'd1;
          vs_d    = 1'b0;
          cnt_d   = '0;
          if (!cfg_q.snap && !(stop_q | stop) && sizes_ok) begin
            state_d = S_FS;
            cfg_d   = cfg_in;
            line_d  = '0;
`ifdef DCMI_GEN_LFSR_EN
            lfsr_d  = SEED;
`endif
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase

    // data and hsync follow the next state so both land on the same edge
    if (state_d == S_LINE) begin
      hs_d = ~cfg_q.embd;
`ifdef DCMI_GEN_LFSR_EN
      data_d = lfsr_q[DW-1:0];
      lfsr_d = lfsr_step(lfsr_q);
`else
      ramp   = frame_q + 16'(line_q) + cnt_d;
      data_d = ramp[DW-1:0];
`endif
    end else if (state_d == S_SAV) begin
      data_d = sync_word(cnt_d[1:0],
                         (line_q == '0) ? cfg_q.fsc : cfg_q.lsc);
    end else if (state_d == S_EAV) begin
      data_d = sync_word(cnt_d[1:0],
                         last_line ? cfg_q.fec : cfg_q.lec);
    end
  end

  always_ff @(posedge pclk_raw or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cfg_q   <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
      frame_q <= '0;
      go_q    <= 1'b0;
      stop_q  <= 1'b0;
      vs_q    <= 1'b0;
      hs_q    <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef DCMI_GEN_LFSR_EN
      lfsr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      cfg_q   <= cfg_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      frame_q <= frame_d;
      go_q    <= go_d;
      stop_q  <= stop_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      data_q  <= data_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef DCMI_GEN_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  // idle pins track the live polarity inputs; a running frame uses the latched ones
  logic idle, ppol, vpol, hpol;
  assign idle = (state_q == S_IDLE);
  assign ppol = idle ? pclk_pol  : cfg_q.ppol;
  assign vpol = idle ? vsync_pol : cfg_q.vpol;
  assign hpol = idle ? hsync_pol : cfg_q.hpol;

  assign dcmi.pclk  = rstn & (pclk_raw ^ ppol);
  assign dcmi.vsync = vpol ^ ~vs_q;
  assign dcmi.hsync = hpol ^ ~hs_q;
  assign dcmi.data  = data_q;

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign cfg_err    = err_q;

endmodule

// File: tb/tb_dcmi_sensor_gen.sv
// tb_dcmi_sensor_gen: self-checking bench for dcmi_sensor_gen.
// Table of frame vectors plus directed reset, cfg_err, stop and LFSR sequences.
`timescale 1ns/1ps
module tb_dcmi_sensor_gen;
`ifdef DCMI_GEN_LFSR_EN
  localparam int DW = 14;
`else
  localparam int DW = 8;
`endif
  localparam int LW = 14;
  localparam int VB = 5;
  localparam int HB = 3;

  logic pclk_raw = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0, stop = 1'b0, snapshot = 1'b1, embd_en = 1'b0;
  logic pclk_pol = 1'b0, vsync_pol = 1'b0, hsync_pol = 1'b0;
  logic [7:0] fsc = 8'h80, fec = 8'h90, lsc = 8'hA0, lec = 8'hB0;
  logic [LW-1:0] line_size = '0, pixel_size = '0;
  logic busy, frame_done, cfg_err;

  int checks = 0;
  int errors = 0;

  dcmi_sensor_gen_if #(.DW(DW)) dif ();

  dcmi_sensor_gen #(
    .DW(DW), .LW(LW), .VBLANK(VB), .HBLANK(HB)
  ) dut (
    .pclk_raw(pclk_raw), .rstn(rstn),
    .start(start), .stop(stop), .snapshot(snapshot),
    .embd_en(embd_en), .pclk_pol(pclk_pol),
    .vsync_pol(vsync_pol), .hsync_pol(hsync_pol),
    .fsc(fsc), .fec(fec), .lsc(lsc), .lec(lec),
    .line_size(line_size), .pixel_size(pixel_size),
    .dcmi(dif),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );

  always #5 pclk_raw = ~pclk_raw;

  typedef struct {
    bit          embd;
    bit          pol;
    int          lines;
    int          pix;
    int          len;
    int          npix;
    int          sum;
    int          first;
    int          last;
    int          nvs;
    int          ncodes;
    logic [47:0] codes;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs one snapshot frame from a negedge and checks it against v.
  task automatic run_frame(input string tag, input vec_t v);
    int cyc, npix, nvs, ncodes, k, blank_nz, pclk_bad, sum, first, last;
    logic busy1, busy_end;
    logic [47:0] codes;
    bit done;
    cyc = 0; npix = 0; nvs = 0; ncodes = 0; k = 0;
    blank_nz = 0; pclk_bad = 0; sum = 0; first = -1; last = -1;
    busy1 = 1'b0; busy_end = 1'b1; codes = '0; done = 0;
    embd_en = v.embd; pclk_pol = v.pol;
    vsync_pol = v.pol; hsync_pol = v.pol; snapshot = 1'b1;
    line_size = LW'(v.lines); pixel_size = LW'(v.pix);
    start = 1'b1;
    @(negedge pclk_raw);
    start = 1'b0;
    while (!done && cyc < 2000) begin
      @(posedge pclk_raw);
      cyc++;
      @(negedge pclk_raw);
      if (cyc == 1) busy1 = busy;
      if (dif.vsync == v.pol) nvs++;
      if (dif.hsync == v.pol) begin
        npix++;
        sum += int'(dif.data);
        if (npix == 1) first = int'(dif.data);
        last = int'(dif.data);
      end else if (!v.embd && dif.data != '0) begin
        blank_nz++;
      end
      if (dif.pclk != v.pol) pclk_bad++;
      if (k > 0) begin
        k++;
        if (k == 4) begin
          codes = {codes[39:0], dif.data[7:0]};
          ncodes++;
          k = 0;
        end
      end else if (v.embd && (&dif.data)) begin
        k = 1;
      end
      if (frame_done) begin
        done = 1;
        busy_end = busy;
      end
    end
    chk({tag, "_len"}, cyc, v.len);
    chk({tag, "_busy1"}, busy1, 1);
    chk({tag, "_busy_end"}, busy_end, 0);
    chk({tag, "_npix"}, npix, v.npix);
    chk({tag, "_sum"}, sum, v.sum);
    chk({tag, "_first"}, first, v.first);
    chk({tag, "_last"}, last, v.last);
    chk({tag, "_nvs"}, nvs, v.nvs);
    chk({tag, "_ncodes"}, ncodes, v.ncodes);
    chk({tag, "_codes"}, codes, v.codes);
    chk({tag, "_blank_nz"}, blank_nz, 0);
    chk({tag, "_pclk"}, pclk_bad, 0);
    repeat (3) @(negedge pclk_raw);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_err"}, cfg_err, 0);
    chk({tag, "_data"}, dif.data, 0);
    chk({tag, "_vsync"}, dif.vsync, 1);
    chk({tag, "_hsync"}, dif.hsync, 1);
    @(posedge pclk_raw);
    #1;
    chk({tag, "_pclk"}, dif.pclk, 0);
  endtask

  vec_t tbl[4];
  vec_t v0;
  vec_t lf;

  initial begin
    int cyc, nd, d1, d2, f2px;
    bit found;

    tbl[0] = '{embd:0, pol:0, lines:2, pix:4, len:27, npix:8,
               sum:32, first:2, last:6, nvs:21, ncodes:0, codes:'0};
    tbl[1] = '{embd:0, pol:1, lines:1, pix:1, len:16, npix:1,
               sum:3, first:3, last:3, nvs:10, ncodes:0, codes:'0};
    tbl[2] = '{embd:0, pol:0, lines:3, pix:5, len:38, npix:15,
               sum:105, first:4, last:10, nvs:32, ncodes:0, codes:'0};
    tbl[3] = '{embd:1, pol:0, lines:3, pix:2, len:53, npix:0,
               sum:0, first:-1, last:-1, nvs:0, ncodes:6,
               codes:48'h80B0A0B0A090};
    v0     = '{embd:0, pol:0, lines:2, pix:4, len:27, npix:8,
               sum:16, first:0, last:4, nvs:21, ncodes:0, codes:'0};
    lf     = '{embd:0, pol:0, lines:1, pix:2, len:17, npix:2,
               sum:17233, first:'h2CE1, last:'h1670, nvs:11,
               ncodes:0, codes:'0};

    @(negedge pclk_raw);
    reset_checks("rst");
    @(negedge pclk_raw);
    rstn = 1'b1;
    repeat (2) @(negedge pclk_raw);

    // zero pixel_size rejected
    line_size = LW'(2);
    pixel_size = '0;
    start = 1'b1;
    @(negedge pclk_raw);
    start = 1'b0;
    chk("cfgerr_pulse", cfg_err, 1);
    chk("cfgerr_busy0", busy, 0);
    @(negedge pclk_raw);
    chk("cfgerr_clear", cfg_err, 0);
    repeat (3) @(negedge pclk_raw);
    chk("cfgerr_busy_late", busy, 0);

`ifdef DCMI_GEN_LFSR_EN
    run_frame("lfsr_f0", lf);
    run_frame("lfsr_f1", lf);
`else
    // continuous mode, stop during the second frame
    embd_en = 1'b0;
    snapshot = 1'b0;
    line_size = LW'(2);
    pixel_size = LW'(4);
    start = 1'b1;
    @(negedge pclk_raw);
    start = 1'b0;
    cyc = 0; nd = 0; d1 = 0; d2 = 0; f2px = -1;
    repeat (150) begin
      @(posedge pclk_raw);
      cyc++;
      @(negedge pclk_raw);
      if (frame_done) begin
        nd++;
        if (nd == 1) d1 = cyc;
        if (nd == 2) d2 = cyc;
      end
      if (nd == 1 && f2px < 0 && dif.hsync == 1'b0)
        f2px = int'(dif.data);
      stop = (nd == 1 && cyc == d1 + 10);
    end
    stop = 1'b0;
    snapshot = 1'b1;
    chk("cont_ndone", nd, 2);
    chk("cont_first_done", d1, 27);
    chk("cont_period", d2 - d1, 26);
    chk("cont_f2px", f2px, 1);
    chk("cont_busy_end", busy, 0);

    foreach (tbl[i])
      run_frame($sformatf("v%0d", i), tbl[i]);

    // reset in the middle of a line
    embd_en = 1'b0;
    pclk_pol = 1'b0; vsync_pol = 1'b0; hsync_pol = 1'b0;
    line_size = LW'(2);
    pixel_size = LW'(4);
    start = 1'b1;
    @(negedge pclk_raw);
    start = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge pclk_raw);
      if (dif.hsync == 1'b0) found = 1;
    end
    chk("midrst_line_seen", found, 1);
    rstn = 1'b0;
    #1;
    reset_checks("midrst");
    @(negedge pclk_raw);
    rstn = 1'b1;
    repeat (2) @(negedge pclk_raw);
    run_frame("post_rst", v0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcmi_sensor_gen.md
# dcmi_sensor_gen

Parametrised, self-contained DCMI camera sensor model for the testbench. It drives pixel clock, VSYNC, HSYNC and a DW-bit data bus in either external-sync or embedded-sync (ITU-656-style code) mode. It generates frame content internally (ramp or LFSR), not from a file, so frame geometry, blanking, polarity and snapshot/continuous behaviour can be swept by the bench. It sits in front of the DCMI capture DUT in `tb_top`.

## Interface
- DW, 8, data bus width; legal 8, 10, 12, 14.
- LW, 14, width of line/pixel size fields.
- VBLANK, 20, pclk cycles of vertical blanking before the first line and after the last line.
- HBLANK, 20, pclk cycles of horizontal blanking before each line.
- pclk_raw  in  1  free-running source clock; all logic on posedge.
- rstn  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins frame generation when idle.
- stop  in  1  one-cycle pulse; continuous mode ends after the current frame.
- snapshot  in  1  1: one frame, then IDLE; 0: continuous.
- embd_en  in  1  1: embedded sync codes; 0: external VSYNC/HSYNC.
- pclk_pol, vsync_pol, hsync_pol  in  1 each  output polarity inversion.
- fsc, fec, lsc, lec  in  8 each  embedded frame/line start/end codes.
- line_size  in  LW  active lines per frame.
- pixel_size  in  LW  active pixels per line.
- dcmi_pclk  out  1  pclk_raw ^ pclk_pol, forced 0 while rstn low.
- dcmi_vsync, dcmi_hsync  out  1  sync outputs after polarity.
- dcmi_data  out  DW  pixel or code word.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at end of each frame's FE blanking.
- cfg_err  out  1  one-cycle pulse when start is rejected.

## Operation
- States: IDLE, FS (VBLANK cycles), LS (HBLANK cycles), SAV (4 words, embedded only), LINE (pixel_size cycles), EAV (4 words, embedded only), LE (1 cycle), FE (VBLANK cycles).
- IDLE -> FS on start when line_size != 0 and pixel_size != 0. Otherwise cfg_err pulses and the block stays in IDLE.
- All config inputs are latched on accepted start and again on every FE->FS transition. Mid-frame input changes are ignored.
- FS -> LS -> [SAV] -> LINE -> [EAV] -> LE. LE goes to LS if more lines remain, otherwise to FE.
- FE exit: frame_done pulses. Next state is FS if !snapshot and no stop is pending, otherwise IDLE. A stop pulse in any state sets stop_pending, which is cleared on IDLE.
- start while busy is ignored (no cfg_err).
- External mode: internal vsync = 1 from FS exit until FE exit. Internal hsync = 1 during LINE. Data is 0 outside LINE.
- Embedded mode: internal vsync/hsync stay 0. The SAV and EAV words are all-ones, 0, 0, then the code.
  - SAV code: fsc on line 0, lsc otherwise.
  - EAV code: fec on the last line, lec otherwise.
  - Codes are zero-extended to DW. Blanking data is 0.
- Output polarity: dcmi_vsync = vsync_pol ^ ~vsync_int, and the same form for hsync. pol=0 therefore gives an active-low sync.
- Pixel data (ramp): (frame_cnt + line_cnt + pixel_cnt) mod 2^DW.
  - frame_cnt is 16-bit and wraps. It increments at frame_done and clears on reset only.
- Reset values: state IDLE, all counters 0, busy 0, frame_done 0, cfg_err 0, dcmi_data 0.
  - dcmi_vsync = vsync_pol ^ 1 and dcmi_hsync = hsync_pol ^ 1, i.e. inactive.
- Reset asserted mid-frame returns the block to IDLE immediately, with all outputs at their reset values.

## Timing
- Accepted start at edge N: busy = 1 after edge N+1. The FS count begins at edge N+1.
- External mode: vsync goes active at the FS->LS edge. The first pixel appears HBLANK cycles later, coincident with hsync going active.
- hsync and data are registered together, with zero skew between them.
- Embedded mode: the first SAV word follows LS by one cycle. The first pixel follows the 4th SAV word directly.
- One frame takes VBLANK + line_size*(HBLANK + pixel_size + 1 + 8*embd_en) + VBLANK + 1 cycles.
- frame_done and a continuous-mode re-entry to FS occur on the same edge.

## Configuration
- DCMI_GEN_LFSR_EN defined: pixel data comes from a 16-bit Fibonacci LFSR with polynomial x^16+x^14+x^13+x^11+1.
  - The LFSR is seeded to 16'hACE1 at each FS entry and advances once per LINE cycle.
  - dcmi_data = lfsr[DW-1:0].
- Macro undefined: ramp pattern as defined in Operation.
- Sync, geometry and timing behaviour are identical with and without the macro.

## Test plan
- DW=8, external mode, snapshot=1, line_size=2, pixel_size=4, pols=0, start -> two low-hsync bursts with data 00,01,02,03 then 01,02,03,04; one frame_done; busy returns to 0.
- embd_en=1, fsc=80, lsc=A0, lec=B0, fec=90, 3 lines -> SAV codes seen are FF,00,00,80 then A0, A0; EAV codes are B0, B0, 90; vsync/hsync pins stay constant.
- Continuous mode, stop pulsed mid-frame 2 -> frame 2 completes, exactly two frame_done pulses, then IDLE; frame 2 line 0 pixel 0 = 01.
- start with pixel_size=0 -> cfg_err pulse, busy stays 0.
- rstn low mid-LINE -> next cycle IDLE, dcmi_data=0, syncs inactive; a later start restarts frame_cnt-independent geometry correctly.
- DW=14, DCMI_GEN_LFSR_EN, pixel_size=2 -> pixels are 0x2CE1 then the next LFSR state's low 14 bits; the sequence repeats identically on the next frame.
